// File: rtl/modred_montgomery_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : modred_montgomery_iter_pkg
// Description : Shared FSM state type and sizing/latency helpers for the
//               word-serial Montgomery reduction stage.
// Revision    : 1.0 - initial release
// ============================================================================
package modred_montgomery_iter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Number of W-bit retirement iterations
    function automatic int calc_k(input int logq, input int w);
        return logq / w;
    endfunction

    // Accept edge to first out_valid edge; summed with other stage latencies
    function automatic int lat(input int logq, input int w);
        return logq / w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/modred_montgomery_iter_mont_step.sv
`default_nettype none
// ============================================================================
// Module      : mont_step
// Description : One Montgomery iteration: ACC' = (ACC + m*Q) >> W,
//               with m = ACC[W-1:0] * QINV mod 2^W. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module mont_step
    import modred_montgomery_iter_pkg::*;
#(
    parameter int                LOGQ     = 60,
    parameter int                W        = 20,
    parameter logic [LOGQ-1:0]   Q        = 60'h0FFF_FFFF_FFFC_0001,
    parameter logic [W-1:0]      QINV     = 20'hBFFFF,
    parameter int                MORE_DSP = 0
) (
    input  logic [2*LOGQ:0] i_acc,
    output logic [2*LOGQ:0] o_acc
);

    logic [W-1:0]      w_m;
    logic [W+LOGQ-1:0] w_mq;
    logic [2*LOGQ:0]   w_sum;

    // Product is evaluated in W-bit context, so it is already reduced mod 2^W
    assign w_m = i_acc[W-1:0] * QINV;

    generate
        if (MORE_DSP != 0) begin : g_mq_dsp
            (* use_dsp = "yes" *) logic [W+LOGQ-1:0] w_prod;
            assign w_prod = {{LOGQ{1'b0}}, w_m} * {{W{1'b0}}, Q};
            assign w_mq   = w_prod;
        end else begin : g_mq_lut
            (* use_dsp = "no" *) logic [W+LOGQ-1:0] w_prod;
            assign w_prod = {{LOGQ{1'b0}}, w_m} * {{W{1'b0}}, Q};
            assign w_mq   = w_prod;
        end
    endgenerate

    // Low W bits of w_sum are zero by construction of m
    assign w_sum = i_acc + {{(LOGQ+1-W){1'b0}}, w_mq};
    assign o_acc = w_sum >> W;

endmodule
`default_nettype wire

// File: rtl/modred_montgomery_iter.sv
`default_nettype none
// ============================================================================
// Module      : modred_montgomery_iter
// Description : Single-entry word-serial Montgomery reduction, T = C*R^-1 mod Q,
//               valid/ready on both sides, K = LOGQ/W iterations plus fix-up.
// Revision    : 1.0 - initial release
// ============================================================================
module modred_montgomery_iter
    import modred_montgomery_iter_pkg::*;
#(
    parameter int                LOGQ     = 60,
    parameter int                W        = 20,
    parameter logic [LOGQ-1:0]   Q        = 60'h0FFF_FFFF_FFFC_0001,
    parameter logic [W-1:0]      QINV     = 20'hBFFFF,
    parameter int                MORE_DSP = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*LOGQ-1:0]   C,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LOGQ-1:0]     T
);

    localparam int              c_K        = calc_k(LOGQ, W);
    localparam int              c_CW       = (c_K > 1) ? $clog2(c_K) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(c_K - 1);
    localparam logic [W-1:0]    c_QCHK     = Q[W-1:0] * QINV + {{(W-1){1'b0}}, 1'b1};

    generate
        if (LOGQ % W != 0) begin : g_chk_width
            $error("modred_montgomery_iter: LOGQ must be a multiple of W");
        end
        if (Q[0] != 1'b1 || Q <= 2) begin : g_chk_q
            $error("modred_montgomery_iter: Q must be odd and greater than 2");
        end
        if (c_QCHK != '0) begin : g_chk_qinv
            $error("modred_montgomery_iter: QINV must equal -Q^-1 mod 2^W");
        end
    endgenerate

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2*LOGQ:0]   r_acc;
    logic [2*LOGQ:0]   w_acc_nxt;
    logic [c_CW-1:0]   r_cnt;
    logic [LOGQ-1:0]   r_t;
    logic              r_out_valid;
    logic              w_ge_q;
    logic [LOGQ-1:0]   w_acc_sub;

    mont_step #(
        .LOGQ     (LOGQ),
        .W        (W),
        .Q        (Q),
        .QINV     (QINV),
        .MORE_DSP (MORE_DSP)
    ) u_step (
        .i_acc (r_acc),
        .o_acc (w_acc_nxt)
    );

    // After K iterations ACC < 2Q, so a single conditional subtract is enough
    assign w_ge_q    = (r_acc >= {{(LOGQ+1){1'b0}}, Q});
    assign w_acc_sub = r_acc[LOGQ-1:0] - Q;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)              w_state_nxt = ST_RUN;
            ST_RUN:  if (r_cnt == c_CNT_LAST)   w_state_nxt = ST_FIX;
            ST_FIX:                             w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready)             w_state_nxt = ST_IDLE;
            default:                            w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_t         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_acc <= {1'b0, C};
                        r_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + c_CW'(1);
                end
                ST_FIX: begin
                    r_t         <= w_ge_q ? w_acc_sub : r_acc[LOGQ-1:0];
                    r_out_valid <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // No input/output overlap: a new C is only taken from IDLE
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign T         = r_t;

endmodule
`default_nettype wire

// File: tb/tb_modred_montgomery_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_modred_montgomery_iter
// Description : Directed and randomized self-checking bench for the Montgomery
//               reduction stage (small LOGQ=8 config and default 60-bit config).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modred_montgomery_iter;

    localparam logic [59:0]  BQ     = 60'h0FFF_FFFF_FFFC_0001;
    localparam int           N_RAND = 5000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Small config: LOGQ=8, W=4, Q=239, QINV=1 (K=2)
    logic        s_rst, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [15:0] s_C;
    logic [7:0]  s_T;

    // Default 60-bit config (K=3)
    logic         b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [119:0] b_C;
    logic [59:0]  b_T;

    modred_montgomery_iter #(
        .LOGQ(8), .W(4), .Q(8'd239), .QINV(4'd1), .MORE_DSP(0)
    ) u_small (
        .clk(clk), .rst(s_rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .C(s_C),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .T(s_T)
    );

    modred_montgomery_iter #(
        .LOGQ(60), .W(20), .Q(BQ), .QINV(20'hBFFFF), .MORE_DSP(1)
    ) u_big (
        .clk(clk), .rst(b_rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .C(b_C),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .T(b_T)
    );

    // Stimulus helper: push one C into the small DUT, wait, pop the result
    task automatic s_xact(input logic [15:0] c, output logic [7:0] t,
                          output int lat_o, output bit rdy_busy);
        rdy_busy   = 1'b0;
        s_C        = c;
        s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        lat_o = 0;
        while (!s_out_valid && lat_o < 20) begin
            if (s_in_ready) rdy_busy = 1'b1;
            @(posedge clk); #1;
            lat_o++;
        end
        if (s_in_ready) rdy_busy = 1'b1;
        t = s_T;
        s_out_ready = 1'b1;
        #1;
        if (s_in_ready) rdy_busy = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        s_rst = 1'b1; b_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_T !== 8'd0) begin
            n_err++;
            $display("FAIL reset_small: in_ready=%b out_valid=%b T=%0d, want 1/0/0", s_in_ready, s_out_valid, s_T);
        end
        n_vec++;
        if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_T !== 60'd0) begin
            n_err++;
            $display("FAIL reset_big: in_ready=%b out_valid=%b T=%0d, want 1/0/0", b_in_ready, b_out_valid, b_T);
        end
        s_rst = 1'b0; b_rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        logic [7:0] t; int l; bit busy;
        s_xact(16'd1280, t, l, busy);
        n_vec++;
        if (t !== 8'd5) begin n_err++; $display("FAIL lat_value: T=%0d, want 5", t); end
        n_vec++;
        if (l != 3) begin n_err++; $display("FAIL lat_cycles: got %0d edges after accept, want 3", l); end
        n_vec++;
        if (busy) begin n_err++; $display("FAIL lat_in_ready: in_ready=1 seen while busy, want 0"); end
    endtask

    task automatic test_intermediate();
        logic [15:0] cv [2];
        logic [16:0] a1 [2];
        logic [16:0] a2 [2];
        logic [7:0]  tv [2];
        int          n;
        cv = '{16'd1, 16'd61183};
        a1 = '{17'd15, 17'd4048};
        a2 = '{17'd225, 17'd253};
        tv = '{8'd225, 8'd14};
        for (int i = 0; i < 2; i++) begin
            s_C = cv[i]; s_in_valid = 1'b1;
            @(posedge clk); #1;
            s_in_valid = 1'b0;
            @(posedge clk); #1;
            n_vec++;
            if (u_small.r_acc !== a1[i]) begin
                n_err++; $display("FAIL acc_iter1 C=%0d: ACC=%0d, want %0d", cv[i], u_small.r_acc, a1[i]);
            end
            @(posedge clk); #1;
            n_vec++;
            if (u_small.r_acc !== a2[i]) begin
                n_err++; $display("FAIL acc_iter2 C=%0d: ACC=%0d, want %0d", cv[i], u_small.r_acc, a2[i]);
            end
            n = 0;
            while (!s_out_valid && n < 20) begin @(posedge clk); #1; n++; end
            n_vec++;
            if (s_out_valid !== 1'b1 || s_T !== tv[i]) begin
                n_err++; $display("FAIL fix_result C=%0d: out_valid=%b T=%0d, want 1/%0d", cv[i], s_out_valid, s_T, tv[i]);
            end
            s_out_ready = 1'b1;
            @(posedge clk); #1;
            s_out_ready = 1'b0;
        end
    endtask

    task automatic test_zero();
        logic [7:0] t; int l; bit busy;
        s_xact(16'd0, t, l, busy);
        n_vec++;
        if (t !== 8'd0 || l != 3) begin
            n_err++; $display("FAIL zero_input: T=%0d lat=%0d, want 0/3", t, l);
        end
    endtask

    task automatic test_stall();
        logic [7:0] t; int l; bit busy;
        s_C = 16'd1280; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        l = 0;
        while (!s_out_valid && l < 20) begin @(posedge clk); #1; l++; end
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin s_C = 16'd1; s_in_valid = 1'b1; end
            if (i == 4) s_in_valid = 1'b0;
            n_vec++;
            if (s_out_valid !== 1'b1 || s_T !== 8'd5 || s_in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold cycle %0d: out_valid=%b T=%0d in_ready=%b, want 1/5/0", i, s_out_valid, s_T, s_in_ready);
            end
            @(posedge clk); #1;
        end
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        s_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL stall_no_accept cycle %0d: out_valid=%b in_ready=%b, want 0/1", i, s_out_valid, s_in_ready);
            end
            @(posedge clk); #1;
        end
        s_xact(16'd61183, t, l, busy);
        n_vec++;
        if (t !== 8'd14) begin n_err++; $display("FAIL stall_next: T=%0d, want 14", t); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] t; int l; bit busy;
        s_C = 16'd61183; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        @(posedge clk); #1;
        s_rst = 1'b1;
        @(posedge clk); #1;
        s_rst = 1'b0;
        n_vec++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || u_small.r_acc !== 17'd0) begin
            n_err++;
            $display("FAIL rst_mid_idle: in_ready=%b out_valid=%b ACC=%0d, want 1/0/0", s_in_ready, s_out_valid, u_small.r_acc);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (s_out_valid !== 1'b0) begin
                n_err++; $display("FAIL rst_mid_quiet cycle %0d: out_valid=%b, want 0", i, s_out_valid);
            end
            @(posedge clk); #1;
        end
        s_xact(16'd1280, t, l, busy);
        n_vec++;
        if (t !== 8'd5 || l != 3) begin
            n_err++; $display("FAIL rst_mid_after: T=%0d lat=%0d, want 5/3", t, l);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0]  a, b;
        logic [127:0] p, tt, q128;
        int           l, st;
        bit           hold_ok;
        q128 = {68'd0, BQ};
        for (int v = 0; v < N_RAND; v++) begin
            a = {$urandom(), $urandom()} % {4'd0, BQ};
            b = {$urandom(), $urandom()} % {4'd0, BQ};
            if (v == 0) begin a = {4'd0, BQ} - 64'd1; b = a; end
            p = {64'd0, a} * {64'd0, b};
            b_C = p[119:0];
            b_in_valid = 1'b1;
            st = 0;
            while (!b_in_ready && st < 20) begin @(posedge clk); #1; st++; end
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            l = 0;
            while (!b_out_valid && l < 30) begin @(posedge clk); #1; l++; end
            tt = {68'd0, b_T};
            hold_ok = 1'b1;
            st = $urandom_range(0, 3);
            for (int i = 0; i < st; i++) begin
                @(posedge clk); #1;
                if (b_out_valid !== 1'b1 || {68'd0, b_T} !== tt || b_in_ready !== 1'b0) hold_ok = 1'b0;
            end
            b_out_ready = 1'b1;
            @(posedge clk); #1;
            b_out_ready = 1'b0;
            n_vec++;
            if (l != 4 || !hold_ok || tt >= q128 || ((tt << 60) % q128) !== (p % q128)) begin
                n_err++;
                $display("FAIL b2b vec %0d: A=%h B=%h T=%h lat=%0d hold=%b, want T*R==A*B mod Q, T<Q, lat=4, hold=1",
                         v, a, b, tt[59:0], l, hold_ok);
            end
        end
    endtask

    initial begin
        s_rst = 1'b1; s_in_valid = 1'b0; s_out_ready = 1'b0; s_C = '0;
        b_rst = 1'b1; b_in_valid = 1'b0; b_out_ready = 1'b0; b_C = '0;
        test_reset();
        test_latency();
        test_intermediate();
        test_zero();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
